// File: rtl/cruise_controller_pkg.sv
// Shared encodings for the cruise controller: FSM states, speed-ALU operation codes
// and the default speed window.
package cruise_controller_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_CRUISE    = 3'd1;
    localparam logic [2:0] ST_STEP_UP   = 3'd2;
    localparam logic [2:0] ST_STEP_DOWN = 3'd3;
    localparam logic [2:0] ST_SUSPEND   = 3'd4;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_CMP  = 2'b01;
    localparam logic [1:0] MODE_IDLE = 2'b10;
    localparam logic [1:0] MODE_SUB  = 2'b11;

    localparam int DEF_MIN_SPEED = 30;
    localparam int DEF_MAX_SPEED = 130;

endpackage

// File: rtl/cruise_controller_button_sync.sv
// Samples accel/decel, detects rises and auto-repeats a held button every REPEAT_CYCLES cycles.
// Pressing both together is treated as no request at all.
module button_sync #(
    parameter int REPEAT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accel,
    input  logic decel,
    output logic up_req,
    output logic down_req
);

    localparam int CW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(REPEAT_CYCLES - 1);

    logic          primed;
    logic          accel_q, accel_p, decel_q, decel_p;
    logic [CW-1:0] cnt;
    logic          held_up, held_dn, rise_up, rise_dn;

    assign held_up = accel_q & ~decel_q;
    assign held_dn = decel_q & ~accel_q;
    assign rise_up = held_up & ~accel_p;
    assign rise_dn = held_dn & ~decel_p;

    assign up_req   = rise_up | (held_up & accel_p & (cnt == '0));
    assign down_req = rise_dn | (held_dn & decel_p & (cnt == '0));

    // The first edge after reset loads both history stages, so a button already
    // held through reset is not seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed  <= 1'b0;
            accel_q <= 1'b0;
            accel_p <= 1'b0;
            decel_q <= 1'b0;
            decel_p <= 1'b0;
            cnt     <= '0;
        end else if (!primed) begin
            primed  <= 1'b1;
            accel_q <= accel;
            accel_p <= accel;
            decel_q <= decel;
            decel_p <= decel;
            cnt     <= '0;
        end else begin
            accel_p <= accel_q;
            accel_q <= accel;
            decel_p <= decel_q;
            decel_q <= decel;
            if (rise_up || rise_dn)
                cnt <= RELOAD;
            else if (!(held_up || held_dn))
                cnt <= '0;
            else if (cnt == '0)
                cnt <= RELOAD;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/cruise_controller.sv
// Cruise controller: engages at the measured speed, steps the target by the speed ALU,
// and drives throttle requests from the ALU compare flags.
//   state      | meaning
//   OFF        | disengaged, target cleared
//   CRUISE     | holding target, ALU compares target vs measured speed
//   STEP_UP    | one cycle, ALU adds 5, result saturated at MAX_SPEED
//   STEP_DOWN  | one cycle, ALU subtracts 5, result saturated at MIN_SPEED
//   SUSPEND    | braked, target retained until resume
module cruise_controller
    import cruise_controller_pkg::*;
#(
    parameter int MIN_SPEED     = DEF_MIN_SPEED,
    parameter int MAX_SPEED     = DEF_MAX_SPEED,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       on,
    input  logic       off,
    input  logic       accel,
    input  logic       decel,
    input  logic       brake,
    input  logic       resume,
    input  logic [7:0] current_speed,
    input  logic [7:0] alu_result,
    input  logic       alu_g,
    input  logic       alu_eq,
    input  logic       alu_l,
    output logic [7:0] alu_default_speed,
    output logic [7:0] alu_current_speed,
    output logic [1:0] alu_mode,
    output logic       cruise_active,
    output logic       suspended,
    output logic       throttle_up,
    output logic       throttle_down,
    output logic [7:0] cruise_speed
);

    localparam logic [7:0] MIN8 = 8'(MIN_SPEED);
    localparam logic [7:0] MAX8 = 8'(MAX_SPEED);

    logic       primed, on_q, on_p, resume_q, resume_p, off_q, brake_q;
    logic       up_req, down_req;
    logic [2:0] state, state_nx;
    logic [7:0] speed_nx, up_speed, down_speed;
    logic       on_rise, resume_rise, in_range, hold_cruise;

    button_sync #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_button_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .accel    (accel),
        .decel    (decel),
        .up_req   (up_req),
        .down_req (down_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed   <= 1'b0;
            on_q     <= 1'b0;
            on_p     <= 1'b0;
            resume_q <= 1'b0;
            resume_p <= 1'b0;
            off_q    <= 1'b0;
            brake_q  <= 1'b0;
        end else begin
            primed   <= 1'b1;
            on_q     <= on;
            on_p     <= primed ? on_q : on;
            resume_q <= resume;
            resume_p <= primed ? resume_q : resume;
            off_q    <= off;
            brake_q  <= brake;
        end
    end

    assign on_rise     = on_q & ~on_p;
    assign resume_rise = resume_q & ~resume_p;
    assign in_range    = (current_speed >= MIN8) && (current_speed <= MAX8);

    // A result below the old target (or above, for a step down) means the ALU wrapped.
    assign up_speed   = (alu_result > MAX8 || alu_result < cruise_speed) ? MAX8 : alu_result;
    assign down_speed = (alu_result < MIN8 || alu_result > cruise_speed) ? MIN8 : alu_result;

    always_comb begin
        state_nx = state;
        speed_nx = cruise_speed;
        if (off_q) begin
            state_nx = ST_OFF;
            speed_nx = '0;
        end else begin
            case (state)
                ST_OFF: if (on_rise && in_range) begin
                    state_nx = ST_CRUISE;
                    speed_nx = current_speed;
                end
                ST_CRUISE: begin
                    if (brake_q)       state_nx = ST_SUSPEND;
                    else if (up_req)   state_nx = ST_STEP_UP;
                    else if (down_req) state_nx = ST_STEP_DOWN;
                end
                ST_STEP_UP: begin
                    if (brake_q) state_nx = ST_SUSPEND;
                    else begin
                        state_nx = ST_CRUISE;
                        speed_nx = up_speed;
                    end
                end
                ST_STEP_DOWN: begin
                    if (brake_q) state_nx = ST_SUSPEND;
                    else begin
                        state_nx = ST_CRUISE;
                        speed_nx = down_speed;
                    end
                end
                ST_SUSPEND: if (!brake_q && resume_rise) state_nx = ST_CRUISE;
                default: begin
                    state_nx = ST_OFF;
                    speed_nx = '0;
                end
            endcase
        end
    end

    assign hold_cruise = (state == ST_CRUISE) && (state_nx == ST_CRUISE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_OFF;
            cruise_speed  <= '0;
            throttle_up   <= 1'b0;
            throttle_down <= 1'b0;
        end else begin
            state         <= state_nx;
            cruise_speed  <= speed_nx;
            throttle_up   <= hold_cruise & alu_g;
            throttle_down <= hold_cruise & ~alu_g & alu_l;
        end
    end

    always_comb begin
        alu_mode = MODE_IDLE;
        case (state)
            ST_CRUISE:    alu_mode = MODE_CMP;
            ST_STEP_UP:   alu_mode = MODE_ADD;
            ST_STEP_DOWN: alu_mode = MODE_SUB;
            default:      alu_mode = MODE_IDLE;
        endcase
    end

    assign alu_default_speed = cruise_speed;
    assign alu_current_speed = current_speed;
    assign cruise_active     = (state == ST_CRUISE) || (state == ST_STEP_UP) || (state == ST_STEP_DOWN);
    assign suspended         = (state == ST_SUSPEND);

endmodule

// File: tb/tb_cruise_controller.sv
// Directed bench for cruise_controller: a per-cycle vector table followed by
// hand-written sequences for saturation, auto-repeat, throttle, brake and reset.
module tb_cruise_controller;

    logic       clk, rst_n;
    logic       on, off, accel, decel, brake, resume;
    logic [7:0] current_speed, alu_result;
    logic       alu_g, alu_eq, alu_l;
    logic [7:0] alu_default_speed, alu_current_speed, cruise_speed;
    logic [1:0] alu_mode;
    logic       cruise_active, suspended, throttle_up, throttle_down;

    logic       ovr;
    logic [2:0] ovr_flags;
    int         n_cmp, n_bad;

    cruise_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .on                (on),
        .off               (off),
        .accel             (accel),
        .decel             (decel),
        .brake             (brake),
        .resume            (resume),
        .current_speed     (current_speed),
        .alu_result        (alu_result),
        .alu_g             (alu_g),
        .alu_eq            (alu_eq),
        .alu_l             (alu_l),
        .alu_default_speed (alu_default_speed),
        .alu_current_speed (alu_current_speed),
        .alu_mode          (alu_mode),
        .cruise_active     (cruise_active),
        .suspended         (suspended),
        .throttle_up       (throttle_up),
        .throttle_down     (throttle_down),
        .cruise_speed      (cruise_speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational speed ALU environment, with optional forced flags.
    always_comb begin
        alu_result = 8'd0;
        alu_g = 1'b0;
        alu_eq = 1'b0;
        alu_l = 1'b0;
        case (alu_mode)
            2'b00:   alu_result = alu_default_speed + 8'd5;
            2'b11:   alu_result = alu_default_speed - 8'd5;
            default: alu_result = 8'd0;
        endcase
        if (ovr)
            {alu_g, alu_eq, alu_l} = ovr_flags;
        else if (alu_mode == 2'b01) begin
            alu_g  = alu_default_speed > alu_current_speed;
            alu_eq = alu_default_speed == alu_current_speed;
            alu_l  = alu_default_speed < alu_current_speed;
        end
    end

    // ctrl = {on, off, accel, decel, brake, resume}; flags = {active, suspended, up, down}
    typedef struct {
        logic [5:0] ctrl;
        logic [7:0] speed;
        logic [7:0] exp_cs;
        logic [3:0] exp_flags;
        logic [1:0] exp_mode;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [5:0] c);
        {on, off, accel, decel, brake, resume} = c;
    endtask

    task automatic engage(input logic [7:0] spd);
        current_speed = spd;
        on = 1'b1;
        tick();
        on = 1'b0;
        tick();
    endtask

    task automatic go_off();
        off = 1'b1;
        tick();
        off = 1'b0;
        tick();
    endtask

    task automatic step(input bit up);
        if (up) accel = 1'b1; else decel = 1'b1;
        tick();
        accel = 1'b0;
        decel = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ovr = 1'b0;
        ovr_flags = 3'b000;
        rst_n = 1'b0;
        set_ctrl(6'b000000);
        current_speed = 8'd60;

        vecs[0]  = '{6'b000000, 8'd20, 8'd0,  4'b0000, 2'd2};
        vecs[1]  = '{6'b100000, 8'd20, 8'd0,  4'b0000, 2'd2};
        vecs[2]  = '{6'b000000, 8'd20, 8'd0,  4'b0000, 2'd2};
        vecs[3]  = '{6'b000000, 8'd60, 8'd0,  4'b0000, 2'd2};
        vecs[4]  = '{6'b100000, 8'd60, 8'd0,  4'b0000, 2'd2};
        vecs[5]  = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[6]  = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[7]  = '{6'b001000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[8]  = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd0};
        vecs[9]  = '{6'b000000, 8'd60, 8'd65, 4'b1000, 2'd1};
        vecs[10] = '{6'b000100, 8'd60, 8'd65, 4'b1010, 2'd1};
        vecs[11] = '{6'b000000, 8'd60, 8'd65, 4'b1000, 2'd3};
        vecs[12] = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[13] = '{6'b001100, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[14] = '{6'b001100, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[15] = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[16] = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[17] = '{6'b000010, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[18] = '{6'b000000, 8'd60, 8'd60, 4'b0100, 2'd2};
        vecs[19] = '{6'b000001, 8'd60, 8'd60, 4'b0100, 2'd2};
        vecs[20] = '{6'b000000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[21] = '{6'b010000, 8'd60, 8'd60, 4'b1000, 2'd1};
        vecs[22] = '{6'b000000, 8'd60, 8'd0,  4'b0000, 2'd2};

        repeat (3) tick();
        check("reset cs", 16'(cruise_speed), 16'd0);
        check("reset mode", 16'(alu_mode), 16'd2);
        check("reset flags", 16'({cruise_active, suspended, throttle_up, throttle_down}), 16'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 23; i++) begin
            set_ctrl(vecs[i].ctrl);
            current_speed = vecs[i].speed;
            tick();
            check($sformatf("v%0d cs", i), 16'(cruise_speed), 16'(vecs[i].exp_cs));
            check($sformatf("v%0d flags", i),
                  16'({cruise_active, suspended, throttle_up, throttle_down}), 16'(vecs[i].exp_flags));
            check($sformatf("v%0d mode", i), 16'(alu_mode), 16'(vecs[i].exp_mode));
            check($sformatf("v%0d alu_ops", i), {alu_default_speed, alu_current_speed},
                  {vecs[i].exp_cs, vecs[i].speed});
        end
        set_ctrl(6'b000000);

        // Saturation at both ends.
        engage(8'd125);
        check("sat engage cs", 16'(cruise_speed), 16'd125);
        step(1'b1);
        check("sat up 1", 16'(cruise_speed), 16'd130);
        step(1'b1);
        check("sat up 2", 16'(cruise_speed), 16'd130);
        go_off();
        engage(8'd32);
        step(1'b0);
        check("sat down", 16'(cruise_speed), 16'd30);
        go_off();

        // Auto-repeat: 20 cycles held gives steps at cycles 0, 8 and 16.
        engage(8'd60);
        accel = 1'b1;
        repeat (20) tick();
        accel = 1'b0;
        repeat (4) tick();
        check("repeat cs", 16'(cruise_speed), 16'd75);
        go_off();

        // Throttle follows forced compare flags one edge later.
        engage(8'd60);
        ovr = 1'b1;
        ovr_flags = 3'b100;
        tick();
        check("thr g", 16'({throttle_up, throttle_down}), 16'b10);
        ovr_flags = 3'b001;
        tick();
        check("thr l", 16'({throttle_up, throttle_down}), 16'b01);
        ovr_flags = 3'b010;
        tick();
        check("thr eq", 16'({throttle_up, throttle_down}), 16'b00);
        ovr = 1'b0;

        // Brake during STEP_UP abandons the step.
        accel = 1'b1;
        tick();
        accel = 1'b0;
        brake = 1'b1;
        tick();
        check("brk in step mode", 16'(alu_mode), 16'd0);
        brake = 1'b0;
        tick();
        check("brk susp", 16'({cruise_active, suspended, throttle_up, throttle_down}), 16'b0100);
        check("brk cs", 16'(cruise_speed), 16'd60);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        check("resume", 16'({cruise_active, suspended}), 16'b10);
        check("resume cs", 16'(cruise_speed), 16'd60);

        // off wins over brake.
        off = 1'b1;
        brake = 1'b1;
        tick();
        off = 1'b0;
        brake = 1'b0;
        tick();
        check("off+brake", 16'({cruise_speed, cruise_active, suspended}), 16'd0);

        // Asynchronous reset mid-operation, then no rise from a held on.
        engage(8'd60);
        ovr = 1'b1;
        ovr_flags = 3'b100;
        tick();
        check("pre-rst thr", 16'(throttle_up), 16'd1);
        on = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async rst cs", 16'(cruise_speed), 16'd0);
        check("async rst flags", 16'({cruise_active, suspended, throttle_up, throttle_down}), 16'd0);
        check("async rst mode", 16'(alu_mode), 16'd2);
        ovr = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("held on after rst", 16'({cruise_active, cruise_speed}), 16'd0);
        on = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
